// File: rtl/shade_motor_ctrl.sv
// shade_motor_ctrl: turns a settle-filtered 4-bit shade request into timed
// up/down motor drive, dead-reckons the shade position one level per step,
// and inserts dead time before any direction reversal.
// Optional macro SHADE_LIMIT_SW_EN adds the lim_top/lim_bot end-stop inputs.
//
// state  | meaning
// IDLE   | no motion, drives off
// RUN_DN | motor_down on, stepping toward closed (position increments)
// RUN_UP | motor_up on, stepping toward open (position decrements)
// DEAD   | both drives off before running the opposite way
module shade_motor_ctrl #(
    parameter int SETTLE_CYCLES = 16,
    parameter int STEP_CYCLES   = 100,
    parameter int DEAD_CYCLES   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] wshade,
`ifdef SHADE_LIMIT_SW_EN
    input  logic       lim_top,
    input  logic       lim_bot,
`endif
    output logic       motor_down,
    output logic       motor_up,
    output logic [3:0] shade_pos,
    output logic [3:0] tgt_level,
    output logic       busy,
    output logic       at_target
);

    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int STW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int DCW = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);
    localparam logic [STW-1:0] STEP_LAST   = STW'(STEP_CYCLES - 1);
    localparam logic [DCW-1:0] DEAD_LAST   = DCW'(DEAD_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RUN_DN, RUN_UP, DEAD} state_t;

    state_t         state_q, state_d;
    logic [3:0]     cand_q, cand_d;
    logic [SCW-1:0] scnt_q, scnt_d;
    logic [3:0]     tgt_q, tgt_d;
    logic [3:0]     pos_q, pos_d;
    logic [STW-1:0] step_cnt_q, step_cnt_d;
    logic [DCW-1:0] dead_cnt_q, dead_cnt_d;
    logic           motor_down_q, motor_down_d;
    logic           motor_up_q, motor_up_d;
    logic           busy_q, busy_d;
    logic           at_target_q, at_target_d;
    logic           lim_top_s, lim_bot_s;
    logic           want_dn, want_up;

`ifdef SHADE_LIMIT_SW_EN
    logic [1:0] top_sync_q, bot_sync_q;

    // Two-flop synchronisers for the asynchronous end-stop switches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_sync_q <= 2'b00;
            bot_sync_q <= 2'b00;
        end else begin
            top_sync_q <= {top_sync_q[0], lim_top};
            bot_sync_q <= {bot_sync_q[0], lim_bot};
        end
    end

    assign lim_top_s = top_sync_q[1];
    assign lim_bot_s = bot_sync_q[1];
`else
    assign lim_top_s = 1'b0;
    assign lim_bot_s = 1'b0;
`endif

    // Never start a run into an end-stop that is currently closed
    assign want_dn = (tgt_q > pos_q) && !lim_bot_s;
    assign want_up = (tgt_q < pos_q) && !lim_top_s;

    // Settle filter: a request must hold for SETTLE_CYCLES before it becomes the target
    always_comb begin
        cand_d = cand_q;
        scnt_d = scnt_q;
        tgt_d  = tgt_q;
        if (wshade != cand_q) begin
            cand_d = wshade;
            scnt_d = '0;
        end else if (cand_q != tgt_q) begin
            if (scnt_q == SETTLE_LAST) begin
                tgt_d  = cand_q;
                scnt_d = '0;
            end else begin
                scnt_d = scnt_q + SCW'(1);
            end
        end
    end

    // Mover: next state, step/dead timers, position tracking and registered outputs
    always_comb begin
        state_d    = state_q;
        pos_d      = pos_q;
        step_cnt_d = step_cnt_q;
        dead_cnt_d = dead_cnt_q;
        case (state_q)
            IDLE: begin
                step_cnt_d = '0;
                if (want_dn)      state_d = RUN_DN;
                else if (want_up) state_d = RUN_UP;
            end
            RUN_DN: begin
                if (lim_bot_s) begin
                    pos_d      = 4'd15;
                    state_d    = IDLE;
                    step_cnt_d = '0;
                end else if (tgt_q == pos_q) begin
                    state_d    = IDLE;
                    step_cnt_d = '0;
                end else if (tgt_q < pos_q) begin
                    state_d    = DEAD;
                    step_cnt_d = '0;
                    dead_cnt_d = '0;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    if (pos_q != 4'd15) pos_d = pos_q + 4'd1;
                    if (pos_d == tgt_q) state_d = IDLE;
                end else begin
                    step_cnt_d = step_cnt_q + STW'(1);
                end
            end
            RUN_UP: begin
                if (lim_top_s) begin
                    pos_d      = 4'd0;
                    state_d    = IDLE;
                    step_cnt_d = '0;
                end else if (tgt_q == pos_q) begin
                    state_d    = IDLE;
                    step_cnt_d = '0;
                end else if (tgt_q > pos_q) begin
                    state_d    = DEAD;
                    step_cnt_d = '0;
                    dead_cnt_d = '0;
                end else if (step_cnt_q == STEP_LAST) begin
                    step_cnt_d = '0;
                    if (pos_q != 4'd0) pos_d = pos_q - 4'd1;
                    if (pos_d == tgt_q) state_d = IDLE;
                end else begin
                    step_cnt_d = step_cnt_q + STW'(1);
                end
            end
            DEAD: begin
                if (dead_cnt_q == DEAD_LAST) begin
                    dead_cnt_d = '0;
                    step_cnt_d = '0;
                    if (want_dn)      state_d = RUN_DN;
                    else if (want_up) state_d = RUN_UP;
                    else              state_d = IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q + DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        motor_down_d = (state_d == RUN_DN);
        motor_up_d   = (state_d == RUN_UP);
        busy_d       = (state_d != IDLE);
        at_target_d  = (pos_d == tgt_d);
    end

    // State and output registers; reset drops both drives immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cand_q       <= 4'd0;
            scnt_q       <= '0;
            tgt_q        <= 4'd0;
            pos_q        <= 4'd0;
            step_cnt_q   <= '0;
            dead_cnt_q   <= '0;
            motor_down_q <= 1'b0;
            motor_up_q   <= 1'b0;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            scnt_q       <= scnt_d;
            tgt_q        <= tgt_d;
            pos_q        <= pos_d;
            step_cnt_q   <= step_cnt_d;
            dead_cnt_q   <= dead_cnt_d;
            motor_down_q <= motor_down_d;
            motor_up_q   <= motor_up_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
        end
    end

    assign motor_down = motor_down_q;
    assign motor_up   = motor_up_q;
    assign shade_pos  = pos_q;
    assign tgt_level  = tgt_q;
    assign busy       = busy_q;
    assign at_target  = at_target_q;

endmodule

// File: tb/tb_shade_motor_ctrl.sv
// Testbench for shade_motor_ctrl: directed scenarios plus random requests,
// checked by a scoreboard fed from a behavioural model of the shade mover.
module tb_shade_motor_ctrl;

    localparam int SETTLE = 4;
    localparam int STEP   = 8;
    localparam int DEAD   = 2;
    localparam int M_IDLE = 0;
    localparam int M_DN   = 1;
    localparam int M_UP   = 2;
    localparam int M_WAIT = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [3:0] wshade = 4'd0;
`ifdef SHADE_LIMIT_SW_EN
    logic       lim_top = 1'b0;
    logic       lim_bot = 1'b0;
`endif
    logic       motor_down, motor_up, busy, at_target;
    logic [3:0] shade_pos, tgt_level;

    shade_motor_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .STEP_CYCLES  (STEP),
        .DEAD_CYCLES  (DEAD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wshade    (wshade),
`ifdef SHADE_LIMIT_SW_EN
        .lim_top   (lim_top),
        .lim_bot   (lim_bot),
`endif
        .motor_down(motor_down),
        .motor_up  (motor_up),
        .shade_pos (shade_pos),
        .tgt_level (tgt_level),
        .busy      (busy),
        .at_target (at_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stamp;
        int tgt;
        int pos;
        int dn;
        int up;
        int busy;
        int at;
    } snap_t;

    snap_t q[$];
    snap_t m_last, m_base, mon_last;
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;

    // reference model state: plain integers, one "phase" per mover activity
    int m_cand, m_stable, m_tgt, m_pos, m_mode, m_prog, m_dwait;
    int lt_p1, lt_p2, lb_p1, lb_p2;

    function automatic void chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", nm, act, exp, $time);
        end
    endfunction

    function automatic bit same(input snap_t a, input snap_t b);
        return a.tgt == b.tgt && a.pos == b.pos && a.dn == b.dn && a.up == b.up
            && a.busy == b.busy && a.at == b.at;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.stamp = 0; s.tgt = 0; s.pos = 0; s.dn = 0; s.up = 0; s.busy = 0; s.at = 1;
        return s;
    endfunction

    function automatic void m_reset();
        m_cand = 0; m_stable = 0; m_tgt = 0; m_pos = 0;
        m_mode = M_IDLE; m_prog = 0; m_dwait = 0;
        lt_p1 = 0; lt_p2 = 0; lb_p1 = 0; lb_p2 = 0;
    endfunction

    // direction wanted toward target, refusing to run into a closed end-stop
    function automatic int pick_dir(input int t, input int p, input int lt, input int lb);
        if (t > p && lb == 0) return M_DN;
        if (t < p && lt == 0) return M_UP;
        return M_IDLE;
    endfunction

    function automatic void m_step();
        int lts, lbs, t;
        t   = m_tgt;
        lts = lt_p2;
        lbs = lb_p2;
        lt_p2 = lt_p1;
        lb_p2 = lb_p1;
`ifdef SHADE_LIMIT_SW_EN
        lt_p1 = int'(lim_top);
        lb_p1 = int'(lim_bot);
`else
        lt_p1 = 0;
        lb_p1 = 0;
`endif
        case (m_mode)
            M_IDLE: begin
                m_mode = pick_dir(t, m_pos, lts, lbs);
                m_prog = 0;
            end
            M_DN: begin
                if (lbs != 0) begin m_pos = 15; m_mode = M_IDLE; m_prog = 0; end
                else if (t == m_pos) begin m_mode = M_IDLE; m_prog = 0; end
                else if (t < m_pos) begin m_mode = M_WAIT; m_dwait = 0; m_prog = 0; end
                else begin
                    m_prog++;
                    if (m_prog == STEP) begin
                        m_prog = 0;
                        m_pos  = (m_pos < 15) ? m_pos + 1 : 15;
                        if (m_pos == t) m_mode = M_IDLE;
                    end
                end
            end
            M_UP: begin
                if (lts != 0) begin m_pos = 0; m_mode = M_IDLE; m_prog = 0; end
                else if (t == m_pos) begin m_mode = M_IDLE; m_prog = 0; end
                else if (t > m_pos) begin m_mode = M_WAIT; m_dwait = 0; m_prog = 0; end
                else begin
                    m_prog++;
                    if (m_prog == STEP) begin
                        m_prog = 0;
                        m_pos  = (m_pos > 0) ? m_pos - 1 : 0;
                        if (m_pos == t) m_mode = M_IDLE;
                    end
                end
            end
            default: begin
                m_dwait++;
                if (m_dwait == DEAD) begin
                    m_dwait = 0;
                    m_prog  = 0;
                    m_mode  = pick_dir(t, m_pos, lts, lbs);
                end
            end
        endcase
        if (int'(wshade) != m_cand) begin
            m_cand   = int'(wshade);
            m_stable = 0;
        end else if (m_cand != m_tgt) begin
            m_stable++;
            if (m_stable == SETTLE) m_tgt = m_cand;
        end
    endfunction

    // push the model's visible outputs whenever they change; a reset in the same
    // cycle as a clocked change collapses into one observable event
    function automatic void m_publish(input int stamp);
        snap_t s;
        s.stamp = stamp;
        s.tgt   = m_tgt;
        s.pos   = m_pos;
        s.dn    = (m_mode == M_DN) ? 1 : 0;
        s.up    = (m_mode == M_UP) ? 1 : 0;
        s.busy  = (m_mode != M_IDLE) ? 1 : 0;
        s.at    = (m_pos == m_tgt) ? 1 : 0;
        if (!same(s, m_last)) begin
            if (q.size() > 0 && q[$].stamp == stamp) begin
                void'(q.pop_back());
                if (!same(s, m_base)) q.push_back(s);
            end else begin
                m_base = m_last;
                q.push_back(s);
            end
            m_last = s;
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_reset();
        else        m_step();
        m_publish(int'($time / 10));
    end

    // monitor: every visible DUT output change must match the next model event
    always @(negedge clk) begin
        if (mon_en) begin
            int    cur;
            snap_t d, ev;
            cur = int'(($time - 10) / 10);
            while (q.size() > 0 && q[0].stamp < cur) begin
                ev = q.pop_front();
                chk("sb_missed_event_cycle", cur, ev.stamp);
            end
            d.stamp = cur;
            d.tgt   = int'(tgt_level);
            d.pos   = int'(shade_pos);
            d.dn    = int'(motor_down);
            d.up    = int'(motor_up);
            d.busy  = int'(busy);
            d.at    = int'(at_target);
            if (!same(d, mon_last)) begin
                if (q.size() == 0) begin
                    chk("sb_unexpected_change_pos", d.pos, mon_last.pos);
                    chk("sb_unexpected_change_drv", d.dn * 2 + d.up, mon_last.dn * 2 + mon_last.up);
                end else begin
                    ev = q.pop_front();
                    chk("sb_cycle", cur, ev.stamp);
                    chk("sb_tgt_level", d.tgt, ev.tgt);
                    chk("sb_shade_pos", d.pos, ev.pos);
                    chk("sb_motor_down", d.dn, ev.dn);
                    chk("sb_motor_up", d.up, ev.up);
                    chk("sb_busy", d.busy, ev.busy);
                    chk("sb_at_target", d.at, ev.at);
                end
                mon_last = d;
            end
        end
    end

    task automatic set_ws(input int v);
        @(posedge clk);
        #2 wshade = 4'(v);
    endtask

    task automatic wait_pos(input int p, input int limit, input string nm);
        int n = 0;
        while (int'(shade_pos) != p && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, int'(shade_pos), p);
    endtask

    task automatic wait_idle_at(input int p, input int limit, input string nm);
        int n = 0;
        while ((busy || int'(shade_pos) != p) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, int'(shade_pos), p);
        chk({nm, "_idle"}, int'(busy), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw;
        int n;
        rst_n  = 1'b0;
        wshade = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_motor_down", int'(motor_down), 0);
        chk("rst_motor_up", int'(motor_up), 0);
        chk("rst_shade_pos", int'(shade_pos), 0);
        chk("rst_tgt_level", int'(tgt_level), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_at_target", int'(at_target), 1);
        #1 rst_n = 1'b1;
        m_last   = reset_snap();
        m_base   = m_last;
        mon_last = reset_snap();
        q.delete();
        mon_en   = 1'b1;

        // idle hold at 0
        saw = 1'b0;
        repeat (50) begin
            @(posedge clk); #1;
            if (motor_down || motor_up || busy || !at_target || shade_pos != 4'd0) saw = 1'b1;
        end
        chk("idle_hold_clean", int'(saw), 0);

        // 2-cycle glitch to 5 must never reach the target
        @(posedge clk);
        #2 wshade = 4'd5;
        repeat (2) @(posedge clk);
        #2 wshade = 4'd0;
        saw = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (motor_down || motor_up || tgt_level != 4'd0) saw = 1'b1;
        end
        chk("glitch_no_effect", int'(saw), 0);

        // 0 -> 3 timing, edge N is the first edge that sees 3
        set_ws(3);
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1 chk("settle_tgt_before_n4", int'(tgt_level), 0);
        @(posedge clk);
        #1 chk("settle_tgt_at_n4", int'(tgt_level), 3);
        chk("drive_off_at_n4", int'(motor_down), 0);
        @(posedge clk);
        #1 chk("drive_on_at_n5", int'(motor_down), 1);
        repeat (8) @(posedge clk);
        #1 chk("pos1_at_n13", int'(shade_pos), 1);
        repeat (8) @(posedge clk);
        #1 chk("pos2_at_n21", int'(shade_pos), 2);
        repeat (8) @(posedge clk);
        #1 chk("pos3_at_n29", int'(shade_pos), 3);
        chk("drive_off_at_n29", int'(motor_down), 0);
        chk("at_target_at_n29", int'(at_target), 1);

        // reversal from closing toward 15 back to 1
        set_ws(15);
        wait_pos(4, 400, "rev_reach_pos4");
        #1 wshade = 4'd1;
        n = 0;
        while (motor_down && n < 50) begin @(posedge clk); #1; n++; end
        chk("rev_down_dropped", int'(motor_down), 0);
        n = 0;
        while (!motor_up && n < 20) begin
            if (motor_down) n = 100;
            @(posedge clk); #1; n++;
        end
        chk("rev_dead_low_cycles", n, DEAD);
        wait_idle_at(1, 400, "rev_end_pos");
        chk("rev_at_target", int'(at_target), 1);

        // asynchronous reset while running toward 9
        set_ws(9);
        n = 0;
        while (!motor_down && n < 50) begin @(posedge clk); #1; n++; end
        chk("run9_started", int'(motor_down), 1);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_motor_down", int'(motor_down), 0);
        chk("arst_motor_up", int'(motor_up), 0);
        chk("arst_shade_pos", int'(shade_pos), 0);
        chk("arst_tgt_level", int'(tgt_level), 0);
        chk("arst_at_target", int'(at_target), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_idle_at(9, 500, "arst_rerun_pos");

`ifdef SHADE_LIMIT_SW_EN
        // bottom end-stop hit at 12 while heading for 15
        set_ws(15);
        wait_pos(12, 400, "lim_reach_pos12");
        #1 lim_bot = 1'b1;
        n = 0;
        while (motor_down && n < 3) begin @(posedge clk); #1; n++; end
        chk("lim_down_dropped", int'(motor_down), 0);
        chk("lim_pos_clamped", int'(shade_pos), 15);
        chk("lim_idle", int'(busy), 0);
        chk("lim_at_target", int'(at_target), 1);
        lim_bot = 1'b0;
`endif

        // random requests, some short enough to be filtered out
        for (int i = 0; i < 40; i++) begin
            set_ws(int'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) repeat (200) @(posedge clk);
            else repeat (int'($urandom_range(1, 30))) @(posedge clk);
        end

        n = 0;
        while ((busy || tgt_level != wshade) && n < 3000) begin @(posedge clk); #1; n++; end
        repeat (5) @(posedge clk);
        #1;
        chk("final_tgt_matches_request", int'(tgt_level), int'(wshade));
        chk("final_at_target", int'(at_target), 1);
        chk("sb_queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shade_motor_ctrl.md
Name: shade_motor_ctrl

Overview:
- Downstream consumer of the window-shade level produced by the shade-degree stage.
- Turns the requested 4-bit shade level into timed up/down motor drive and tracks the shade position, one level per step.
- Filters requested-level glitches with a settle window.
- Inserts dead time before any motor direction reversal.

Parameters:
- SETTLE_CYCLES, 16: consecutive stable cycles needed before a new requested level is accepted (≥1).
- STEP_CYCLES, 100: motor-on cycles per one-level position step (≥1).
- DEAD_CYCLES, 8: cycles with both drives low between opposite-direction runs (≥1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- wshade  input  4  requested shade level; 0 = fully open, 15 = fully closed.
- motor_down  output  1  drive shade toward closed (position increments).
- motor_up  output  1  drive shade toward open (position decrements).
- shade_pos  output  4  current tracked position.
- tgt_level  output  4  accepted (settled) target level.
- busy  output  1  high in any state other than IDLE.
- at_target  output  1  high when shade_pos == tgt_level.
- lim_top, lim_bot  input  1 each  end-stop switches; present only with SHADE_LIMIT_SW_EN.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - motor_down = 0, motor_up = 0
  - shade_pos = 0 (the shade is homed open at reset), tgt_level = 0
  - busy = 0, at_target = 1
  - internal candidate = 0, all counters = 0, state = IDLE
- Reset mid-motion drops both drives in the same cycle (asynchronous).
- Settle filter runs every cycle, independent of the mover:
  - If wshade != cand: cand <= wshade, scnt <= 0.
  - Else if cand != tgt_level and scnt == SETTLE_CYCLES-1: tgt_level <= cand.
  - Else if cand != tgt_level: scnt++.
  - A wshade change seen at edge N loads tgt_level at edge N+SETTLE_CYCLES if it stays stable.
  - A glitch shorter than that never reaches tgt_level.
- Mover states: IDLE, RUN_DN, RUN_UP, DEAD. All outputs are registered.
  - motor_down = 1 only in RUN_DN; motor_up = 1 only in RUN_UP. Both drives are never high together.
- IDLE:
  - tgt_level > shade_pos → RUN_DN.
  - tgt_level < shade_pos → RUN_UP.
  - Drive asserts at the edge after tgt_level changes. Step counter starts at 0.
- RUN_DN / RUN_UP: step counter increments each edge.
  - At the STEP_CYCLES-th edge, shade_pos moves ±1 and the counter clears.
  - If the new shade_pos equals tgt_level, go to IDLE and deassert the drive at that same edge.
- tgt_level change while running:
  - Same direction, still beyond shade_pos: continue; the partial step is kept.
  - tgt_level == shade_pos: go to IDLE next edge; discard the partial step; shade_pos unchanged.
  - Opposite side of shade_pos: go to DEAD; discard the partial step.
- DEAD:
  - Both drives low for DEAD_CYCLES edges.
  - Then re-evaluate as in IDLE, going to RUN_x or IDLE.
- Arithmetic: shade_pos saturates at 0 and 15. Counters are sized by $clog2 of their parameter and never wrap mid-step.

Optional Feature:
- Macro: SHADE_LIMIT_SW_EN.
- Defined: lim_top and lim_bot exist (synchronised by 2 flops internally).
  - Synchronised lim_bot high in RUN_DN → shade_pos <= 15, go to IDLE, motor_down low next edge.
  - Synchronised lim_top high in RUN_UP → shade_pos <= 0, go to IDLE, motor_up low next edge.
  - A limit hit with tgt_level beyond the clamped position holds IDLE and does not re-run toward that limit.
- Undefined: the ports are absent and position is dead-reckoned only.

Test Plan:
- Bench parameters: SETTLE=4, STEP=8, DEAD=2.
- Reset, then wshade=0 held → shade_pos=0, both drives 0, at_target=1, busy=0 for 50 cycles.
- wshade 0→3 seen at edge N → tgt_level=3 at N+4; motor_down=1 from N+5; shade_pos=1,2,3 at N+13, N+21, N+29; motor_down=0 at N+29; at_target=1.
- wshade pulses to 5 for 2 cycles then back to 0 → tgt_level stays 0; no drive ever asserted.
- Closing toward 15: at shade_pos=4 mid-step, wshade set to 1 and settled → motor_down drops; 2 cycles with both drives low; motor_up runs; shade_pos reaches 1 with no lost or extra step.
- Running toward 9: rst_n pulsed low for 1 cycle → drives low immediately; shade_pos=0, tgt_level=0; after release the mover re-settles to wshade=9 and runs again.
- With SHADE_LIMIT_SW_EN, target 15, lim_bot asserted at shade_pos=12 → motor_down low within 3 edges; shade_pos=15; IDLE; at_target=1.
